mpx_arb_nto1: RTL and testbench

Parametrised N-to-1 data selector with a registered, flow-controlled output stage. It generalises the datapath 4:1 mux to any channel count and width. Channels are chosen either by an external select (fixed mode) or by round-robin arbitration among valid requesters. Valid/ready handshakes sit on every channel. It sits between multiple pipeline sources (e.g. writeback/forwarding candidates, debug/memory request ports) and a single consumer.

---
 rtl/mpx_arb_nto1_pkg.sv | 8 +
 rtl/mpx_arb_nto1_rr_grant.sv | 28 ++
 rtl/mpx_arb_nto1.sv | 105 ++++++++++
 tb/tb_mpx_arb_nto1.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mpx_arb_nto1_pkg.sv
// Shared constants for the N-to-1 arbitrated selector.
// Mode encodings select fixed-index or round-robin channel choice.
package mpx_arb_nto1_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/mpx_arb_nto1_rr_grant.sv
// Round-robin grant search: first requester after ptr wins, with wrap.
// Purely combinational.
module rr_grant #(
    parameter int N_INPUTS = 4,
    parameter int NB_SEL   = $clog2(N_INPUTS)
) (
    input  logic [N_INPUTS-1:0] req_i,
    input  logic [NB_SEL-1:0]   ptr_i,
    output logic [NB_SEL-1:0]   gnt_o,
    output logic                any_o
);

    always_comb begin
        int idx;
        idx   = 0;
        gnt_o = '0;
        any_o = 1'b0;
        // Walk the search order backwards so the nearest hit is written last.
        for (int k = N_INPUTS; k >= 1; k--) begin
            idx = (int'(ptr_i) + k) % N_INPUTS;
            if (req_i[idx]) begin
                gnt_o = NB_SEL'(idx);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mpx_arb_nto1.sv
// N-to-1 data selector with registered valid/ready output stage.
// Channel chosen by external index or round-robin arbitration.
module mpx_arb_nto1
    import mpx_arb_nto1_pkg::*;
#(
    parameter int NB_DATA  = 32,
    parameter int N_INPUTS = 4,
    parameter int NB_SEL   = $clog2(N_INPUTS)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [N_INPUTS*NB_DATA-1:0] i_data,
    input  logic [N_INPUTS-1:0]         i_valid,
    output logic [N_INPUTS-1:0]         o_ready,
    input  logic [NB_SEL-1:0]           i_sel,
    input  logic                        i_mode,
    output logic [NB_DATA-1:0]          o_data,
    output logic                        o_valid,
    output logic [NB_SEL-1:0]           o_sel,
    input  logic                        i_ready
);

    logic               valid_q, valid_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic [NB_SEL-1:0]  sel_q, sel_d;
    logic [NB_SEL-1:0]  ptr_q, ptr_d;

    logic               load;
    logic               fix_any;
    logic [NB_SEL-1:0]  rr_gnt;
    logic               rr_any;
    logic [NB_SEL-1:0]  gnt;
    logic               any;
    logic [NB_DATA-1:0] gnt_data;

    rr_grant #(
        .N_INPUTS (N_INPUTS),
        .NB_SEL   (NB_SEL)
    ) u_rr_grant (
        .req_i (i_valid),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt),
        .any_o (rr_any)
    );

    always_comb begin
        load    = !valid_q || i_ready;
        fix_any = 1'b0;
        // Out-of-range index (non-power-of-2 channel count) never grants.
        if (int'(i_sel) < N_INPUTS) begin
            fix_any = i_valid[i_sel];
        end
        if (i_mode == MODE_RR) begin
            gnt = rr_gnt;
            any = rr_any;
        end else begin
            gnt = i_sel;
            any = fix_any;
        end
        gnt_data = '0;
        if (any) begin
            gnt_data = i_data[int'(gnt)*NB_DATA +: NB_DATA];
        end
        o_ready = '0;
        if (load && any && i_rst_n) begin
            o_ready[gnt] = 1'b1;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = any;
            if (any) begin
                data_d = gnt_data;
                sel_d  = gnt;
                if (i_mode == MODE_RR) begin
                    ptr_d = gnt;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= NB_SEL'(N_INPUTS - 1);
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_sel   = sel_q;

endmodule

// File: tb/tb_mpx_arb_nto1.sv
// Scoreboard bench for mpx_arb_nto1 (4 channels, 32-bit data).
// Stimulus pushes expected beats; a monitor pops on each output accept.
module tb_mpx_arb_nto1;

    localparam int NB_DATA  = 32;
    localparam int N_INPUTS = 4;
    localparam int NB_SEL   = 2;

    logic                        clk;
    logic                        rst_n;
    logic [N_INPUTS*NB_DATA-1:0] i_data;
    logic [N_INPUTS-1:0]         i_valid;
    logic [N_INPUTS-1:0]         o_ready;
    logic [NB_SEL-1:0]           i_sel;
    logic                        i_mode;
    logic [NB_DATA-1:0]          o_data;
    logic                        o_valid;
    logic [NB_SEL-1:0]           o_sel;
    logic                        i_ready;

    int tests = 0;
    int fails = 0;
    logic [23:0] tag = 24'h0;
    logic [NB_SEL+NB_DATA-1:0] expq[$];

    mpx_arb_nto1 #(
        .NB_DATA  (NB_DATA),
        .N_INPUTS (N_INPUTS),
        .NB_SEL   (NB_SEL)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_sel   (i_sel),
        .i_mode  (i_mode),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_sel   (o_sel),
        .i_ready (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dval(input logic [23:0] t, input int k);
        return {t, 8'(k)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic m,
                         input logic [1:0] s, input logic r);
        tag++;
        for (int k = 0; k < N_INPUTS; k++) begin
            i_data[k*NB_DATA +: NB_DATA] = dval(tag, k);
        end
        i_valid = v;
        i_mode  = m;
        i_sel   = s;
        i_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int g);
        expq.push_back({2'(g), dval(tag, g)});
    endtask

    // Monitor: a beat is consumed on each edge where o_valid && i_ready.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL sb_extra: got sel %0d data %h expected none",
                         o_sel, o_data);
            end else begin
                logic [NB_SEL+NB_DATA-1:0] e;
                e = expq.pop_front();
                if ({o_sel, o_data} !== e) begin
                    fails++;
                    $display("FAIL sb_beat: got sel %0d data %h expected sel %0d data %h",
                             o_sel, o_data, e[NB_DATA +: NB_SEL], e[NB_DATA-1:0]);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        i_data  = '0;
        rst_n   = 1'b0;
        drive(4'hF, 1'b1, 2'd0, 1'b1);
        tick();
        tick();
        chk("rst_o_valid", 32'(o_valid), 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_sel", 32'(o_sel), 0);
        chk("rst_o_ready", 32'(o_ready), 0);

        rst_n = 1'b1;
        #1;
        chk("rr_first_ready", 32'(o_ready), 32'h1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) drive(4'hF, 1'b1, 2'd0, 1'b1);
            push(i % 4);
            tick();
            chk("rr_valid_cont", 32'(o_valid), 1);
            chk("rr_sel_seq", 32'(o_sel), 32'(i % 4));
        end

        drive(4'b0100, 1'b0, 2'd2, 1'b1);
        i_data[2*NB_DATA +: NB_DATA] = 32'hDEADBEEF;
        #1;
        chk("fix_ready", 32'(o_ready), 32'h4);
        expq.push_back({2'd2, 32'hDEADBEEF});
        tick();
        chk("fix_data", o_data, 32'hDEADBEEF);
        chk("fix_sel", 32'(o_sel), 2);

        drive(4'b1011, 1'b0, 2'd2, 1'b1);
        #1;
        chk("fix_nogrant_ready", 32'(o_ready), 0);
        tick();
        chk("fix_nogrant_valid", 32'(o_valid), 0);

        drive(4'b0010, 1'b1, 2'd0, 1'b1);
        push(1);
        held = dval(tag, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(4'hF, 1'b1, 2'd0, 1'b0);
            #1;
            chk("stall_ready", 32'(o_ready), 0);
            tick();
            chk("stall_data", o_data, held);
            chk("stall_sel", 32'(o_sel), 1);
            chk("stall_valid", 32'(o_valid), 1);
        end
        drive(4'hF, 1'b1, 2'd0, 1'b1);
        #1;
        chk("unstall_ready", 32'(o_ready), 32'h4);
        push(2);
        tick();
        chk("unstall_sel", 32'(o_sel), 2);

        drive(4'b0001, 1'b1, 2'd0, 1'b1);
        push(0);
        tick();
        drive(4'b1001, 1'b1, 2'd0, 1'b1);
        push(3);
        tick();
        chk("rr_1001_a", 32'(o_sel), 3);
        drive(4'b1001, 1'b1, 2'd0, 1'b1);
        push(0);
        tick();
        chk("rr_1001_b", 32'(o_sel), 0);

        drive(4'b1000, 1'b1, 2'd0, 1'b1);
        push(3);
        tick();
        drive(4'hF, 1'b1, 2'd0, 1'b1);
        push(0);
        tick();
        drive(4'hF, 1'b1, 2'd0, 1'b1);
        push(1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(4'hF, 1'b0, 2'd3, 1'b1);
            push(3);
            tick();
            chk("mode_fix_sel", 32'(o_sel), 3);
        end
        drive(4'hF, 1'b1, 2'd3, 1'b1);
        push(2);
        tick();
        chk("mode_rr_resume", 32'(o_sel), 2);
        drive(4'h0, 1'b1, 2'd0, 1'b1);
        tick();

        drive(4'b0010, 1'b1, 2'd0, 1'b1);
        tick();
        drive(4'hF, 1'b1, 2'd0, 1'b0);
        tick();
        chk("pre_rst_valid", 32'(o_valid), 1);
        chk("pre_rst_sel", 32'(o_sel), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(o_valid), 0);
        chk("mid_rst_ready", 32'(o_ready), 0);
        chk("mid_rst_data", o_data, 0);
        tick();
        drive(4'hF, 1'b1, 2'd0, 1'b1);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(o_ready), 32'h1);
        push(0);
        tick();
        chk("post_rst_sel", 32'(o_sel), 0);
        drive(4'h0, 1'b1, 2'd0, 1'b1);
        tick();
        tick();
        chk("sb_drained", 32'(expq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
